// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM:
// state encodings, opcode/funct values, ALU operations, datapath mux
// encodings, and the helpers that decode opcode/funct.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_RWB     = 4'd7,
    S_EXEC_I  = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_TRAP    = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLT = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_src_e;

  typedef enum logic [1:0] {
    B_RT     = 2'd0,
    B_FOUR   = 2'd1,
    B_IMM    = 2'd2,
    B_IMM_SH = 2'd3
  } alu_src_b_e;

  // Successor of DECODE; S_TRAP marks an instruction this core does not implement.
  function automatic state_e decode_next(input logic [5:0] opcode, input logic [5:0] funct);
    state_e nxt;
    nxt = S_TRAP;
    case (opcode)
      OP_LW, OP_SW:     nxt = S_MEMADDR;
      OP_ADDI, OP_SLTI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:   nxt = S_BRANCH;
      OP_J:             nxt = S_JUMP;
      OP_JAL:           nxt = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = S_EXEC_R;
          FN_JR:                                 nxt = S_JR;
          default:                               nxt = S_TRAP;
        endcase
      end
      default:          nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  // ALU operation for a legal arithmetic R-type funct.
  function automatic alu_op_e funct_alu_op(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_SLT:  op = ALU_SLT;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Unified memory port handshake between the control FSM (master) and
// the memory (slave). The address itself lives in the datapath; the
// controller only steers it with iord.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl_watchdog.sv
// mc_stall_watchdog: counts consecutive stalled wait-state cycles and
// raises a sticky timeout when the count reaches STALL_MAX. The counter
// saturates at STALL_MAX. STALL_MAX = 0 disables the watchdog.
module mc_stall_watchdog #(
  parameter int unsigned STALL_MAX = 15,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall,
  output logic timeout
);

  localparam logic [CNT_W-1:0] MAX_C   = STALL_MAX[CNT_W-1:0];
  localparam bit               ENABLED = (STALL_MAX != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Next count and sticky flag; any non-stall cycle clears the count.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (stall) begin
      cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
      if (ENABLED && (cnt_d == MAX_C)) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Counter and flag registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences PC, the unified memory port,
// IR, register file, ALU and ALUOut/MDR. Outputs are decoded from the
// state (pc_we also looks at zero and mem_ready) and are forced low
// while reset_n is asserted.
// Build option: define MIPS_CTRL_TRAP_EN to trap illegal instructions in
// the TRAP state with a sticky illegal_instr flag; otherwise they retire
// as NOPs from DECODE.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STALL_MAX = 15,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [5:0]                   opcode,
  input  logic [5:0]                   funct,
  input  logic                         zero,
  mips_multicycle_ctrl_if.master       mem,
  output logic                         ir_we,
  output logic                         pc_we,
  output logic [1:0]                   pc_src,
  output logic                         reg_we,
  output logic [1:0]                   reg_dst,
  output logic [1:0]                   wb_src,
  output logic                         alu_src_a,
  output logic [1:0]                   alu_src_b,
  output logic [2:0]                   alu_op,
  output logic                         instr_done,
  output logic                         mem_timeout,
  output logic                         illegal_instr,
  output logic [3:0]                   state
);

  state_e state_q, state_d;
  state_e dec_nxt;
  logic   mem_req_c, mem_we_c, iord_c;
  logic   in_wait;

`ifdef MIPS_CTRL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  assign dec_nxt = decode_next(opcode, funct);

  // Next state and per-state control decode.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    wb_src     = WB_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = B_RT;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
`ifdef MIPS_CTRL_TRAP_EN
    illegal_d  = illegal_q;
`endif

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = B_FOUR;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = B_IMM_SH;
        if (dec_nxt == S_TRAP) begin
`ifdef MIPS_CTRL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_TRAP;
`else
          instr_done = 1'b1;
          state_d    = S_FETCH;
`endif
        end else begin
          state_d = dec_nxt;
        end
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = B_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        wb_src     = WB_MDR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem.mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu_op(funct);
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_we     = 1'b1;
        reg_dst    = DST_RD;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = B_IMM;
        alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_we      = (opcode == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        pc_src     = PC_JUMP;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = DST_RA;
        wb_src     = WB_PC;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_src     = PC_RS;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
`ifdef MIPS_CTRL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // Hold every control low while reset is asserted so nothing reaches the datapath.
    if (!reset_n) begin
      mem_req_c  = 1'b0;
      mem_we_c   = 1'b0;
      iord_c     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_ALU;
      reg_we     = 1'b0;
      reg_dst    = DST_RT;
      wb_src     = WB_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = B_RT;
      alu_op     = ALU_ADD;
      instr_done = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

`ifdef MIPS_CTRL_TRAP_EN
  // Sticky illegal-instruction flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mc_stall_watchdog #(
    .STALL_MAX (STALL_MAX),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .stall   (in_wait && !mem.mem_ready),
    .timeout (mem_timeout)
  );

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign mem.iord    = iord_c;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl (STALL_MAX=15). Inputs change
// 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ir_we, pc_we, reg_we, alu_src_a, instr_done, mem_timeout, illegal_instr;
  logic [1:0] pc_src, reg_dst, wb_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mips_multicycle_ctrl_if mem_if ();

  mips_multicycle_ctrl #(.STALL_MAX(15), .CNT_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem           (mem_if.master),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .reg_we        (reg_we),
    .reg_dst       (reg_dst),
    .wb_src        (wb_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .mem_timeout   (mem_timeout),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  always #5 clk = ~clk;

  // All 19 control bits in one vector:
  // {req, we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_src, a, b, alu_op, done}
  logic [18:0] ctl_obs;
  assign ctl_obs = {mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_we, pc_we, pc_src,
                    reg_we, reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, instr_done};

  function automatic logic [18:0] pk(input logic req, input logic we, input logic io,
                                     input logic irw, input logic pcw, input logic [1:0] psrc,
                                     input logic rw, input logic [1:0] rdst, input logic [1:0] wbs,
                                     input logic a, input logic [1:0] b, input logic [2:0] op,
                                     input logic done);
    return {req, we, io, irw, pcw, psrc, rw, rdst, wbs, a, b, op, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check state and controls for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [18:0] ec);
    #1;
    check({tag, "_state"}, {28'd0, state}, {28'd0, st});
    check({tag, "_ctl"}, {13'd0, ctl_obs}, {13'd0, ec});
    @(posedge clk);
    #1;
  endtask

  task automatic run_r(input string tag, input logic [5:0] fn, input logic [2:0] op);
    opcode = 6'h00; funct = fn; mem_if.mem_ready = 1'b1;
    cyc({tag, "_fetch"},  4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc({tag, "_decode"}, 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc({tag, "_exec"},   4'd6, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,op,0));
    cyc({tag, "_rwb"},    4'd7, pk(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0,3'd0,1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    mem_if.mem_ready = 1'b1;

    // Reset: controls held low even though FETCH would otherwise request.
    #2;
    check("rst_ctl", {13'd0, ctl_obs}, 32'd0);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    check("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    @(posedge clk); #1;
    check("rst_edge_ctl", {13'd0, ctl_obs}, 32'd0);
    reset_n = 1'b1;

    // ADD 0x01782020, then the other arithmetic functs.
    run_r("add", 6'h20, 3'd0);
    run_r("sub", 6'h22, 3'd1);
    run_r("and", 6'h24, 3'd3);
    run_r("or",  6'h25, 3'd4);
    run_r("slt", 6'h2A, 3'd2);

    // LW 0x8E080004 with three stalled MEMRD cycles: 8 cycles total.
    opcode = 6'h23; funct = 6'h04; mem_if.mem_ready = 1'b1;
    cyc("lw_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    mem_if.mem_ready = 1'b0;
    cyc("lw_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("lw_memaddr", 4'd2, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd0,0));
    for (int i = 0; i < 3; i++) begin
      cyc("lw_memrd_stall", 4'd3, pk(1,0,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0));
    end
    mem_if.mem_ready = 1'b1;
    cyc("lw_memrd_ready", 4'd3, pk(1,0,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0));
    cyc("lw_memwb", 4'd4, pk(0,0,0,0,0,2'd0,1,2'd0,2'd1,0,2'd0,3'd0,1));
    check("lw_timeout", {31'd0, mem_timeout}, 32'd0);

    // SW: MEMWR holds on one stall, retires on ready.
    opcode = 6'h2B;
    cyc("sw_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("sw_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("sw_memaddr", 4'd2, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd0,0));
    mem_if.mem_ready = 1'b0;
    cyc("sw_memwr_stall", 4'd5, pk(1,1,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0));
    mem_if.mem_ready = 1'b1;
    cyc("sw_memwr_ready", 4'd5, pk(1,1,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,1));

    // BEQ 0x11090003 taken and not taken, BNE not-zero taken.
    opcode = 6'h04; zero = 1'b1;
    cyc("beq1_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("beq1_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("beq1_branch", 4'd10, pk(0,0,0,0,1,2'd1,0,2'd0,2'd0,1,2'd0,3'd1,1));
    zero = 1'b0;
    cyc("beq0_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("beq0_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("beq0_branch", 4'd10, pk(0,0,0,0,0,2'd1,0,2'd0,2'd0,1,2'd0,3'd1,1));
    opcode = 6'h05;
    cyc("bne_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("bne_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("bne_branch", 4'd10, pk(0,0,0,0,1,2'd1,0,2'd0,2'd0,1,2'd0,3'd1,1));

    // J, JAL 0x0C000010, JR.
    opcode = 6'h02;
    cyc("j_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("j_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("j_jump", 4'd11, pk(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,2'd0,3'd0,1));
    opcode = 6'h03; funct = 6'h10;
    cyc("jal_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("jal_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("jal_jal", 4'd12, pk(0,0,0,0,1,2'd2,1,2'd2,2'd2,0,2'd0,3'd0,1));
    opcode = 6'h00; funct = 6'h08;
    cyc("jr_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("jr_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("jr_jr", 4'd13, pk(0,0,0,0,1,2'd3,0,2'd0,2'd0,0,2'd0,3'd0,1));

    // ADDI and SLTI.
    opcode = 6'h08;
    cyc("addi_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("addi_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("addi_exec", 4'd8, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd0,0));
    cyc("addi_iwb", 4'd9, pk(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0,3'd0,1));
    opcode = 6'h0A;
    cyc("slti_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("slti_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("slti_exec", 4'd8, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd2,0));
    cyc("slti_iwb", 4'd9, pk(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0,3'd0,1));
    check("pre_wd_timeout", {31'd0, mem_timeout}, 32'd0);

    // Watchdog: 20 stalled FETCH cycles; flag visible from the 16th cycle on.
    opcode = 6'h00; funct = 6'h20; mem_if.mem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      check("wd_timeout", {31'd0, mem_timeout}, (i > 15) ? 32'd1 : 32'd0);
      check("wd_ir_we", {31'd0, ir_we}, 32'd0);
      check("wd_req", {31'd0, mem_if.mem_req}, 32'd1);
      check("wd_state", {28'd0, state}, 32'd0);
      @(posedge clk); #1;
    end
    mem_if.mem_ready = 1'b1;
    cyc("wd_fetch_done", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("wd_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    check("wd_sticky", {31'd0, mem_timeout}, 32'd1);
    cyc("wd_exec", 4'd6, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,3'd0,0));
    cyc("wd_rwb", 4'd7, pk(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0,3'd0,1));

    // Reset asserted mid-MEMWR: outputs drop at once, FETCH after release.
    opcode = 6'h2B;
    cyc("rsw_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    cyc("rsw_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    cyc("rsw_memaddr", 4'd2, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd0,0));
    mem_if.mem_ready = 1'b0;
    #1;
    check("rsw_memwr_state", {28'd0, state}, 32'd5);
    reset_n = 1'b0;
    #1;
    check("rsw_rst_ctl", {13'd0, ctl_obs}, 32'd0);
    check("rsw_rst_state", {28'd0, state}, 32'd0);
    check("rsw_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    @(posedge clk); #1;
    check("rsw_rst_edge_ctl", {13'd0, ctl_obs}, 32'd0);
    reset_n = 1'b1;
    mem_if.mem_ready = 1'b0;
    cyc("rsw_post_fetch", 4'd0, pk(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
    mem_if.mem_ready = 1'b1;

    // Illegal opcode 0x3F.
    opcode = 6'h3F;
    cyc("ill_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
`ifdef MIPS_CTRL_TRAP_EN
    cyc("ill_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ill_trap_flag", {31'd0, illegal_instr}, 32'd1);
      cyc("ill_trap", 4'd14, 19'd0);
    end
    reset_n = 1'b0;
    #1;
    check("ill_rst_flag", {31'd0, illegal_instr}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    opcode = 6'h00;
    cyc("ill_post_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
`else
    cyc("ill_decode", 4'd1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,1));
    #1;
    check("ill_flag", {31'd0, illegal_instr}, 32'd0);
    cyc("ill_post_fetch", 4'd0, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the shared MIPS datapath: PC, unified memory port, IR, register file, ALU and the ALUOut/MDR registers.
- Consumes opcode/funct from instructiondecode.
- Emits per-cycle mux selects, write enables and memory requests.
- Stalls on a memory ready handshake and flags memory that stays unresponsive.

Parameters:
STALL_MAX, 15, consecutive mem_ready=0 cycles in a wait state before mem_timeout sets; 0 disables the watchdog
CNT_W, 8, stall counter width; STALL_MAX must be < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
opcode  input  6  from instructiondecode; valid from DECODE onward
funct  input  6  from instructiondecode; valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  write (with mem_req)
iord  output  1  memory address select: 0=PC, 1=ALUOut
ir_we  output  1  IR load enable
pc_we  output  1  PC load enable (branch condition already resolved)
pc_src  output  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target, 3=rs
reg_we  output  1  register-file write enable
reg_dst  output  2  destination register: 0=rt, 1=rd, 2=$31
wb_src  output  2  write-back source: 0=ALUOut, 1=MDR, 2=PC
alu_src_a  output  1  ALU A input: 0=PC, 1=rs
alu_src_b  output  2  ALU B input: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_op  output  3  0=ADD, 1=SUB, 2=SLT, 3=AND, 4=OR
instr_done  output  1  one-cycle pulse on the final cycle of each instruction
mem_timeout  output  1  sticky watchdog flag
illegal_instr  output  1  sticky trap flag (see Optional Feature)
state  output  4  current state, for debug

Behaviour:
- Reset (reset_n low): state=FETCH, stall counter=0, sticky flags=0.
  - All control outputs are forced 0 while reset_n=0.
  - First fetch request goes out in the first cycle after deassertion.
- Reset mid-instruction: abandons the instruction with no further writes.
- Outputs are combinational from state; pc_we additionally depends on zero and mem_ready.
- Unlisted outputs are 0 in every state.
- State encodings and cycle behaviour:
  - FETCH(0): mem_req, iord=0, a=0, b=1, ADD. On mem_ready: ir_we=1, pc_we=1, pc_src=0, go to DECODE. Otherwise hold.
  - DECODE(1): a=0, b=3, ADD (branch target into ALUOut). Next state:
    - LW 0x23 / SW 0x2B -> MEMADDR
    - R-type 0x00 with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25 or SLT 0x2A -> EXEC_R
    - R-type with funct JR 0x08 -> JR
    - ADDI 0x08 / SLTI 0x0A -> EXEC_I
    - BEQ 0x04 / BNE 0x05 -> BRANCH
    - J 0x02 -> JUMP
    - JAL 0x03 -> JAL
    - anything else -> illegal
  - MEMADDR(2): a=1, b=2, ADD; LW -> MEMRD, SW -> MEMWR.
  - MEMRD(3): mem_req, iord=1; on mem_ready -> MEMWB (MDR captures on mem_ready).
  - MEMWB(4): reg_we, reg_dst=0, wb_src=1, instr_done -> FETCH.
  - MEMWR(5): mem_req, mem_we, iord=1; on mem_ready: instr_done -> FETCH.
  - EXEC_R(6): a=1, b=0, alu_op from funct -> RWB.
  - RWB(7): reg_we, reg_dst=1, wb_src=0, instr_done -> FETCH.
  - EXEC_I(8): a=1, b=2, ADD for ADDI / SLT for SLTI -> IWB.
  - IWB(9): reg_we, reg_dst=0, wb_src=0, instr_done -> FETCH.
  - BRANCH(10): a=1, b=0, SUB, pc_src=1, pc_we = zero (BEQ) or !zero (BNE), instr_done -> FETCH.
  - JUMP(11): pc_src=2, pc_we, instr_done -> FETCH.
  - JAL(12): pc_src=2, pc_we, reg_we, reg_dst=2, wb_src=2 (PC already +4), instr_done -> FETCH.
  - JR(13): pc_src=3, pc_we, instr_done -> FETCH.
  - TRAP(14): only with the macro; all controls 0.
  - Encoding 15 is unreachable; decodes to FETCH on the next edge.
- Memory handshake and watchdog:
  - Wait states are FETCH, MEMRD and MEMWR.
  - mem_req stays high and the address stays stable until mem_ready; mem_ready outside wait states is ignored.
  - The stall counter increments each wait-state cycle with mem_ready=0 and clears on mem_ready or state change.
  - When the counter equals STALL_MAX, mem_timeout sets and stays set until reset. The counter saturates and the FSM keeps waiting.
- Latencies with mem_ready held 1: R/I-type 4 cycles, LW 5, SW 4, branch/J/JAL/JR 3.

Optional Feature:
MIPS_CTRL_TRAP_EN
- Defined: an illegal opcode/funct in DECODE moves to TRAP.
  - illegal_instr sets and sticks; instr_done is not pulsed.
  - The FSM stays in TRAP until reset.
- Undefined: an illegal instruction executes as a NOP.
  - DECODE pulses instr_done and returns to FETCH.
  - illegal_instr is tied 0; TRAP is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum
  - opcode and funct constants
  - alu_op codes
  - pc_src, reg_dst, wb_src and alu_src_b encodings
- Sub-module mc_stall_watchdog (counter + sticky flag, parameterised by STALL_MAX/CNT_W); FSM inline.

Test Plan:
- mem_ready=1, instr 0x01782020 (ADD): FETCH, DECODE, EXEC_R, RWB. In cycle 4: reg_we=1, reg_dst=1, wb_src=0, instr_done=1.
- LW 0x8E080004 with mem_ready=0 for 3 cycles in MEMRD: 8 cycles total, mem_req held, MEMWB asserts reg_we with wb_src=1, mem_timeout=0.
- BEQ 0x11090003: zero=1 -> cycle 3 pc_we=1, pc_src=1. Repeat with zero=0 -> pc_we=0, instr_done=1.
- JAL 0x0C000010: cycle 3 pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_src=2.
- mem_ready=0 for 20 FETCH cycles, STALL_MAX=15: mem_timeout rises after the 15th stall cycle, ir_we=0 throughout; fetch completes when mem_ready returns.
- Opcode 0x3F: with macro -> state=14 and illegal_instr=1 until reset. Without macro -> instr_done in DECODE, then FETCH. Reset pulsed in MEMWR -> all outputs 0 immediately, FETCH after release.
